// File: rtl/ac_sine_detector_if.sv
// Sample stream in and measurement record out of the AC sine detector.
// The slave modport is the detector's view; master is the driver/sweep-controller view.
interface ac_sine_detector_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 24
);
  logic                     s_valid;
  logic signed [DATA_W-1:0] s_data;
  logic                     s_ready;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_vmax;
  logic signed [DATA_W-1:0] m_vmin;
  logic        [DATA_W:0]   m_vpp;
  logic        [CNT_W-1:0]  m_period;
  logic                     m_timeout;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_vmax, m_vmin, m_vpp, m_period, m_timeout
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_vmax, m_vmin, m_vpp, m_period, m_timeout
  );
endinterface

// File: rtl/ac_sine_detector.sv
// Measures max, min, peak-to-peak and the length of NCYC periods of a signed
// sample stream, using hysteretic rising zero crossings as period markers.
module ac_sine_detector #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 24,
  parameter int NCYC   = 4,
  parameter int HYST   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               busy,
  ac_sine_detector_if.slave  bus
);

  localparam int NC_W = $clog2(NCYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HYST_NEG = DATA_W'(-HYST);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t                   state_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [NC_W-1:0]          ncross_reg;
  logic                     arm_reg;
  logic                     init_reg;
  logic signed [DATA_W-1:0] vmax_reg;
  logic signed [DATA_W-1:0] vmin_reg;

  logic                     s_ready_reg;
  logic                     busy_reg;
  logic                     m_valid_reg;
  logic                     m_timeout_reg;
  logic signed [DATA_W-1:0] m_vmax_reg;
  logic signed [DATA_W-1:0] m_vmin_reg;
  logic [DATA_W:0]          m_vpp_reg;
  logic [CNT_W-1:0]         m_period_reg;

  logic                     accept;
  logic                     below;
  logic                     above;
  logic                     crossing;
  logic                     arm_next;
  logic [CNT_W-1:0]         cnt_next;
  logic [NC_W-1:0]          ncross_next;
  logic                     saturate;
  logic                     meas_done;
  logic signed [DATA_W-1:0] vmax_next;
  logic signed [DATA_W-1:0] vmin_next;
  logic [DATA_W:0]          vpp_next;

  always_comb begin
    accept      = bus.s_valid && s_ready_reg;
    below       = bus.s_data < HYST_NEG;
    above       = bus.s_data >= HYST_POS;
    crossing    = accept && arm_reg && above;
    arm_next    = arm_reg;
    if (accept && below) begin
      arm_next = 1'b1;
    end else if (crossing) begin
      arm_next = 1'b0;
    end
    cnt_next    = cnt_reg + CNT_W'(1);
    ncross_next = ncross_reg + NC_W'(1);
    saturate    = (cnt_next == CNT_MAX);
    meas_done   = crossing && (ncross_next == NC_W'(NCYC));
    // First MEASURE sample seeds both extremes so the tracked range is never stale.
    vmax_next   = (!init_reg || (bus.s_data > vmax_reg)) ? bus.s_data : vmax_reg;
    vmin_next   = (!init_reg || (bus.s_data < vmin_reg)) ? bus.s_data : vmin_reg;
    // Sign-extend before subtracting so full-scale swings cannot wrap.
    vpp_next    = {vmax_next[DATA_W-1], vmax_next} - {vmin_next[DATA_W-1], vmin_next};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      ncross_reg    <= '0;
      arm_reg       <= 1'b0;
      init_reg      <= 1'b0;
      vmax_reg      <= '0;
      vmin_reg      <= '0;
      s_ready_reg   <= 1'b1;
      busy_reg      <= 1'b0;
      m_valid_reg   <= 1'b0;
      m_timeout_reg <= 1'b0;
      m_vmax_reg    <= '0;
      m_vmin_reg    <= '0;
      m_vpp_reg     <= '0;
      m_period_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_reg <= ARM;
            cnt_reg   <= '0;
            arm_reg   <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end

        ARM: begin
          if (!en) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (accept) begin
            arm_reg <= arm_next;
            if (crossing) begin
              state_reg  <= MEASURE;
              cnt_reg    <= '0;
              ncross_reg <= '0;
              init_reg   <= 1'b0;
            end else if (saturate) begin
              // Never saw a crossing: no extremes were tracked.
              state_reg     <= DONE;
              s_ready_reg   <= 1'b0;
              busy_reg      <= 1'b0;
              m_valid_reg   <= 1'b1;
              m_timeout_reg <= 1'b1;
              m_vmax_reg    <= '0;
              m_vmin_reg    <= '0;
              m_vpp_reg     <= '0;
              m_period_reg  <= CNT_MAX;
            end else begin
              cnt_reg <= cnt_next;
            end
          end
        end

        MEASURE: begin
          if (!en) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (accept) begin
            arm_reg  <= arm_next;
            cnt_reg  <= cnt_next;
            vmax_reg <= vmax_next;
            vmin_reg <= vmin_next;
            init_reg <= 1'b1;
            if (crossing) begin
              ncross_reg <= ncross_next;
            end
            // A final crossing landing on the saturating sample is still a clean result.
            if (meas_done || saturate) begin
              state_reg     <= DONE;
              s_ready_reg   <= 1'b0;
              busy_reg      <= 1'b0;
              m_valid_reg   <= 1'b1;
              m_timeout_reg <= !meas_done;
              m_vmax_reg    <= vmax_next;
              m_vmin_reg    <= vmin_next;
              m_vpp_reg     <= vpp_next;
              m_period_reg  <= cnt_next;
            end
          end
        end

        DONE: begin
          if (bus.m_ready) begin
            m_valid_reg <= 1'b0;
            s_ready_reg <= 1'b1;
            if (en) begin
              state_reg <= ARM;
              cnt_reg   <= '0;
              arm_reg   <= 1'b0;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_reg;
  assign bus.s_ready   = s_ready_reg;
  assign bus.m_valid   = m_valid_reg;
  assign bus.m_timeout = m_timeout_reg;
  assign bus.m_vmax    = m_vmax_reg;
  assign bus.m_vmin    = m_vmin_reg;
  assign bus.m_vpp     = m_vpp_reg;
  assign bus.m_period  = m_period_reg;

endmodule

// File: tb/tb_ac_sine_detector.sv
// Directed bench: table of square-wave measurements plus hand-written
// backpressure, abort, reset-in-DONE and timeout sequences.
module tb_ac_sine_detector;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en8 = 1'b0;
  logic busy;
  logic busy8;

  int checks = 0;
  int errors = 0;

  ac_sine_detector_if #(.DATA_W(16), .CNT_W(24)) bus ();
  ac_sine_detector_if #(.DATA_W(16), .CNT_W(8))  bus8 ();

  ac_sine_detector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .busy  (busy),
    .bus   (bus.slave)
  );

  ac_sine_detector #(.CNT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en8),
    .busy  (busy8),
    .bus   (bus8.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    int lo;
    int hi;
    int half;
    bit gaps;
    int exp_max;
    int exp_min;
    int exp_vpp;
    int exp_per;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  function automatic logic [DW-1:0] wave(input int lo, input int hi, input int half, input int idx);
    int v;
    v = (((idx / half) % 2) == 0) ? lo : hi;
    return DW'(v);
  endfunction

  // Drive the square wave until m_valid appears; done_idx is the index of the
  // sample whose acceptance made m_valid visible, or -1 if the bound expired.
  task automatic run_meas(input int lo, input int hi, input int half, input bit gaps,
                          output int done_idx);
    int idx = 0;
    int cyc = 0;
    done_idx = -1;
    while (done_idx < 0 && idx < 12 * half && cyc < 4000) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        bus.s_valid = 1'b0;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = wave(lo, hi, half, idx);
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.s_valid) begin
        if (bus.m_valid) done_idx = idx;
        idx++;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  // Feed n samples unconditionally and count cycles where m_valid was seen.
  task automatic feed(input int lo, input int hi, input int half, input int n,
                      output int nvalid);
    nvalid = 0;
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = wave(lo, hi, half, i);
      @(posedge clk); #1;
      if (bus.m_valid) nvalid++;
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    int done_idx;
    int nvalid;

    vecs[0] = '{lo: -1000,  hi: 1000,  half: 10, gaps: 1'b0, exp_max: 1000,  exp_min: -1000,  exp_vpp: 2000,  exp_per: 80};
    vecs[1] = '{lo: -1000,  hi: 1000,  half: 10, gaps: 1'b1, exp_max: 1000,  exp_min: -1000,  exp_vpp: 2000,  exp_per: 80};
    vecs[2] = '{lo: -32768, hi: 32767, half: 10, gaps: 1'b0, exp_max: 32767, exp_min: -32768, exp_vpp: 65535, exp_per: 80};
    vecs[3] = '{lo: -3000,  hi: 500,   half: 7,  gaps: 1'b0, exp_max: 500,   exp_min: -3000,  exp_vpp: 3500,  exp_per: 56};
    vecs[4] = '{lo: -65,    hi: 64,    half: 3,  gaps: 1'b1, exp_max: 64,    exp_min: -65,    exp_vpp: 129,   exp_per: 24};

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b1;
    bus8.s_valid = 1'b0;
    bus8.s_data  = '0;
    bus8.m_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("reset m_valid", longint'(bus.m_valid), 0);
    check("reset s_ready", longint'(bus.s_ready), 1);
    check("reset busy", longint'(busy), 0);
    check("reset m_vmax", longint'(bus.m_vmax), 0);
    check("reset m_vpp", longint'(bus.m_vpp), 0);
    check("reset m_period", longint'(bus.m_period), 0);
    check("reset m_timeout", longint'(bus.m_timeout), 0);

    // Table-driven measurements
    for (int v = 0; v < 5; v++) begin
      en = 1'b1;
      @(posedge clk); #1;
      check($sformatf("v%0d busy armed", v), longint'(busy), 1);
      run_meas(vecs[v].lo, vecs[v].hi, vecs[v].half, vecs[v].gaps, done_idx);
      check($sformatf("v%0d done sample", v), done_idx, 9 * vecs[v].half);
      check($sformatf("v%0d m_vmax", v), longint'(bus.m_vmax), vecs[v].exp_max);
      check($sformatf("v%0d m_vmin", v), longint'(bus.m_vmin), vecs[v].exp_min);
      check($sformatf("v%0d m_vpp", v), longint'(bus.m_vpp), vecs[v].exp_vpp);
      check($sformatf("v%0d m_period", v), longint'(bus.m_period), vecs[v].exp_per);
      check($sformatf("v%0d m_timeout", v), longint'(bus.m_timeout), 0);
      en = 1'b0;
      @(posedge clk); #1;
      check($sformatf("v%0d m_valid after hs", v), longint'(bus.m_valid), 0);
      check($sformatf("v%0d vpp held", v), longint'(bus.m_vpp), vecs[v].exp_vpp);
    end

    // Backpressure: result held, s_ready low, en ignored while DONE
    bus.m_ready = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    run_meas(-1000, 1000, 10, 1'b0, done_idx);
    check("bp done sample", done_idx, 90);
    for (int k = 0; k < 5; k++) begin
      en = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(5000);
      @(posedge clk); #1;
      check($sformatf("bp%0d m_valid", k), longint'(bus.m_valid), 1);
      check($sformatf("bp%0d s_ready", k), longint'(bus.s_ready), 0);
      check($sformatf("bp%0d m_vmax", k), longint'(bus.m_vmax), 1000);
      check($sformatf("bp%0d m_vpp", k), longint'(bus.m_vpp), 2000);
      check($sformatf("bp%0d m_period", k), longint'(bus.m_period), 80);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    check("bp release busy", longint'(busy), 1);
    check("bp release m_valid", longint'(bus.m_valid), 0);
    check("bp release s_ready", longint'(bus.s_ready), 1);

    // Abort mid-MEASURE: no result must ever appear
    feed(-1000, 1000, 10, 35, nvalid);
    check("abort busy before", longint'(busy), 1);
    en = 1'b0;
    @(posedge clk); #1;
    check("abort busy", longint'(busy), 0);
    feed(-1000, 1000, 10, 100, nvalid);
    check("abort no result", nvalid, 0);

    // Reset while a result is pending
    bus.m_ready = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    run_meas(-1000, 1000, 10, 1'b0, done_idx);
    check("rst pending m_valid", longint'(bus.m_valid), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b0;
    check("rst m_valid", longint'(bus.m_valid), 0);
    check("rst s_ready", longint'(bus.s_ready), 1);
    check("rst busy", longint'(busy), 0);
    check("rst m_period", longint'(bus.m_period), 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst result lost", longint'(bus.m_valid), 0);
    bus.m_ready = 1'b1;

    // Hysteresis band only: CNT_W=8 instance must time out in ARM
    en8 = 1'b1;
    @(posedge clk); #1;
    done_idx = -1;
    for (int i = 0; i < 400 && done_idx < 0; i++) begin
      bus8.s_valid = 1'b1;
      bus8.s_data  = DW'(((i % 2) == 0) ? 50 : -50);
      @(posedge clk); #1;
      if (bus8.m_valid) done_idx = i;
    end
    bus8.s_valid = 1'b0;
    check("to done sample", done_idx, 254);
    check("to m_timeout", longint'(bus8.m_timeout), 1);
    check("to m_period", longint'(bus8.m_period), 255);
    check("to m_vmax", longint'(bus8.m_vmax), 0);
    check("to m_vmin", longint'(bus8.m_vmin), 0);
    check("to m_vpp", longint'(bus8.m_vpp), 0);
    en8 = 1'b0;
    @(posedge clk); #1;
    check("to m_valid after hs", longint'(bus8.m_valid), 0);
    check("to busy idle", longint'(busy8), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ac_sine_detector.md
Name: ac_sine_detector

Overview:
- Digital receive-end counterpart of the AC sine stimulus used in the filter characterisation benches.
- Accepts a signed sample stream taken at a filter output and measures the stimulus response over NCYC waveform periods.
- Measures peak maximum, peak minimum, peak-to-peak amplitude and total period length in samples.
- Delivers one result record per measurement over a valid/ready handshake to the sweep controller.

Parameters:
- DATA_W, 16, sample width (signed two's complement)
- CNT_W, 24, sample counter width; also sets the timeout limit
- NCYC, 4, number of periods measured (>=1)
- HYST, 64, zero-crossing hysteresis threshold (positive, < 2^(DATA_W-1))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  measurement enable; a rising level starts a measurement
- s_valid  in  1  input sample valid
- s_data  in  DATA_W  signed sample
- s_ready  out  1  sample accept
- m_valid  out  1  result valid
- m_ready  in  1  result accept
- m_vmax  out  DATA_W  signed maximum sample
- m_vmin  out  DATA_W  signed minimum sample
- m_vpp  out  DATA_W+1  unsigned m_vmax-m_vmin
- m_period  out  CNT_W  samples spanning NCYC periods
- m_timeout  out  1  measurement aborted by counter saturation
- busy  out  1  high in ARM or MEASURE

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: state IDLE, all outputs 0 except s_ready=1, counters cleared, arm flag cleared.
- Sample accept: a sample is accepted when s_valid&&s_ready.
- s_ready: 1 in IDLE, ARM and MEASURE; 0 in DONE.
- Rising crossing detection:
  - arm flag sets on an accepted sample with s_data < -HYST.
  - A crossing occurs on an accepted sample with s_data >= +HYST while the arm flag is set; that sample clears the arm flag.
  - Samples between -HYST and +HYST change nothing.
- IDLE:
  - Accepted samples are discarded.
  - en=1 moves to ARM; cnt=0, arm flag=0.
- ARM:
  - cnt increments per accepted sample.
  - The first crossing moves to MEASURE: cnt=0, ncross=0, vmax/vmin not yet initialised.
- MEASURE:
  - Per accepted sample: cnt+=1.
  - The first MEASURE sample initialises vmax=vmin=s_data; later samples update signed max/min.
  - A crossing sets ncross+=1; the crossing sample itself counts in cnt and max/min.
  - When ncross reaches NCYC, move to DONE.
  - Ideal period P gives m_period=NCYC*P.
- Timeout: if cnt reaches 2^CNT_W-1 in ARM or MEASURE, move to DONE with m_timeout=1 and m_period=2^CNT_W-1.
  - vmax/vmin report whatever has been tracked; 0 if never initialised.
- DONE:
  - m_valid=1 on the cycle after the completing sample is accepted (latency 1).
  - Outputs are registered and held stable while m_valid&&!m_ready.
  - On m_valid&&m_ready: m_valid=0 next cycle; go to ARM if en=1, else IDLE.
  - Result fields keep their last values after the handshake.
- m_vpp: computed in DATA_W+1 bits with sign extension, so the full-scale range never wraps.
- en=0 in ARM or MEASURE: return to IDLE next cycle, no result produced, partial data discarded.
- en is ignored in DONE until handshake.
- rst_n=0 at any state, including DONE with pending m_valid: all reset values next edge, result lost.
- s_valid=0 cycles: no state or counter change (gaps allowed).
- busy = (state==ARM || state==MEASURE).

Test Plan:
- Defaults. Stream (-1000 x10, +1000 x10) repeated, en=1, m_ready=1 -> m_vmax=1000, m_vmin=-1000, m_vpp=2000, m_period=80, m_timeout=0, m_valid one cycle after the 5th +1000 onset is accepted.
- Same stream with random s_valid gaps (50%) -> identical result values.
- Hysteresis. Stream alternating +-50 with CNT_W=8 -> no crossings; after 255 samples m_timeout=1, m_period=255, m_vmax=m_vmin=0, m_vpp=0.
- Backpressure. After a valid result, m_ready=0 for 5 cycles -> s_ready=0, all result fields stable. Then m_ready=1 with en=1 -> ARM next cycle, busy=1.
- Extremes, DATA_W=16. Waveform hitting +32767/-32768 -> m_vpp=65535 (no wrap).
- Abort. en=0 mid-MEASURE, then rst_n=0 in DONE with m_valid=1 -> IDLE, m_valid=0, no result emitted, s_ready=1 next cycle.
